// File: rtl/spi_slave_responder_if.sv
// Streaming tx/rx word ports between the SPI responder and its local client.
interface spi_slave_responder_if #(
  parameter int DATABITS = 8
);
  logic [DATABITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [DATABITS-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI responder, CPOL=0/CPHA=1, MSB first. All SPI pins are oversampled in clk;
// words stream in/out through a valid/ready interface.
module spi_slave_responder #(
  parameter int                  DATABITS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [DATABITS-1:0] IDLE_FILL   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCLK,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_oe,
  spi_slave_responder_if.slave strm,
  output logic                 busy,
  output logic                 rx_overrun,
  output logic                 tx_underrun,
  input  logic                 status_clear
);
  localparam int               CNT_W = $clog2(DATABITS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATABITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_s, ss_s, mosi_s, sclk_p;
  logic                   rise, fall;

  logic [1:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATABITS-1:0] tx_shift, tx_hold;
  logic                tx_full, fill_word, armed;
  logic [DATABITS-2:0] rx_shift;
  logic [DATABITS-1:0] rx_next, rx_data;
  logic                rx_valid;

  logic load_go, shift_go, word_done, tx_fire, rx_pop;
  logic ovr_set, und_set;

  // SS_n chain resets to "selected" so a frame cut by reset must be seen
  // genuinely deselected (armed) before a new one is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_p    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_p    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_p;
  assign fall   = ~sclk_s & sclk_p;

  assign load_go   = (state == ST_LOAD) & ~ss_s;
  assign shift_go  = (state == ST_SHIFT) & ~ss_s;
  assign word_done = shift_go & fall & (bit_cnt == LAST);
  assign rx_next   = {rx_shift, mosi_s};
  assign tx_fire   = strm.tx_valid & ~tx_full;
  assign rx_pop    = rx_valid & strm.rx_ready;

  assign busy          = armed & ~ss_s;
  assign strm.tx_ready = ~tx_full;
  assign strm.rx_data  = rx_data;
  assign strm.rx_valid = rx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      fill_word <= 1'b0;
      armed     <= 1'b0;
      MISO      <= 1'b0;
      MISO_oe   <= 1'b0;
    end else begin
      if (ss_s) armed <= 1'b1;
      if (ss_s) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        MISO    <= 1'b0;
        MISO_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= '0;
            if (armed) state <= ST_LOAD;
          end
          ST_LOAD: begin
            tx_shift  <= tx_full ? tx_hold : IDLE_FILL;
            fill_word <= ~tx_full;
            bit_cnt   <= '0;
            MISO_oe   <= 1'b1;
            state     <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (rise) begin
              MISO     <= tx_shift[DATABITS-1];
              tx_shift <= tx_shift << 1;
            end
            if (fall) begin
              rx_shift <= rx_next[DATABITS-2:0];
              if (bit_cnt == LAST) begin
                bit_cnt <= '0;
                state   <= ST_LOAD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Underrun is raised when a fill word actually starts shifting (first rise),
  // so the speculative reload after a frame's last word does not flag it.
  assign und_set = shift_go & rise & (bit_cnt == '0) & fill_word;
  assign ovr_set = word_done & rx_valid & ~strm.rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full     <= 1'b0;
      tx_hold     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (tx_fire) begin
        tx_full <= 1'b1;
        tx_hold <= strm.tx_data;
      end else if (load_go & tx_full) begin
        tx_full <= 1'b0;
      end

      if (word_done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end

      if (ovr_set)           rx_overrun <= 1'b1;
      else if (status_clear) rx_overrun <= 1'b0;

      if (und_set)           tx_underrun <= 1'b1;
      else if (status_clear) tx_underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench: a CPHA=1 master model drives SCLK at clk/8 against the responder.
module tb_spi_slave_responder;
  logic clk = 1'b0;
  logic reset, SCLK, SS_n, MOSI, MISO, MISO_oe, busy, rx_overrun, tx_underrun, status_clear;
  int   nvec = 0;
  int   nerr = 0;

  spi_slave_responder_if #(.DATABITS(8)) strm();

  spi_slave_responder #(.DATABITS(8), .SYNC_STAGES(2), .IDLE_FILL(8'h00)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .strm(strm), .busy(busy),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .status_clear(status_clear)
  );

  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // master shifts n bits MSB first; MOSI changes on rise, MISO sampled before fall
  task automatic xfer_bits(input logic [7:0] w, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b1; MOSI = w[7-i];
      clks(4);
      r = {r[6:0], MISO};
      SCLK = 1'b0;
      clks(4);
    end
  endtask

  task automatic frame1(input logic [7:0] w, output logic [7:0] r);
    SS_n = 1'b0; clks(4);
    xfer_bits(w, 8, r);
    clks(2); SS_n = 1'b1; clks(6);
  endtask

  task automatic tx_put(input logic [7:0] d);
    strm.tx_data = d; strm.tx_valid = 1'b1; clks(1); strm.tx_valid = 1'b0;
  endtask

  task automatic rx_take();
    strm.rx_ready = 1'b1; clks(1); strm.rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    status_clear = 1'b1; clks(1); status_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clks(3);
    nvec++; if (MISO !== 1'b0)      begin nerr++; $display("FAIL rst_miso: got %b want 0", MISO); end
    nvec++; if (MISO_oe !== 1'b0)   begin nerr++; $display("FAIL rst_oe: got %b want 0", MISO_oe); end
    nvec++; if (strm.rx_data !== 8'h00) begin nerr++; $display("FAIL rst_rxdata: got %h want 00", strm.rx_data); end
    nvec++; if (strm.rx_valid !== 1'b0) begin nerr++; $display("FAIL rst_rxvalid: got %b want 0", strm.rx_valid); end
    nvec++; if (busy !== 1'b0)      begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    nvec++; if (rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin nerr++; $display("FAIL rst_flags: got %b%b want 00", rx_overrun, tx_underrun); end
    nvec++; if (strm.tx_ready !== 1'b1) begin nerr++; $display("FAIL rst_txready: got %b want 1", strm.tx_ready); end
    reset = 1'b0; clks(8);
  endtask

  task automatic test_basic();
    logic [7:0] r;
    tx_put(8'hA5);
    nvec++; if (strm.tx_ready !== 1'b0) begin nerr++; $display("FAIL t1_txfull: got %b want 0", strm.tx_ready); end
    SS_n = 1'b0; clks(4);
    nvec++; if (busy !== 1'b1 || MISO_oe !== 1'b1) begin nerr++; $display("FAIL t1_busy_oe: got %b%b want 11", busy, MISO_oe); end
    xfer_bits(8'h3C, 8, r);
    clks(2); SS_n = 1'b1; clks(6);
    nvec++; if (r !== 8'hA5)             begin nerr++; $display("FAIL t1_miso: got %h want a5", r); end
    nvec++; if (strm.rx_data !== 8'h3C)  begin nerr++; $display("FAIL t1_rxdata: got %h want 3c", strm.rx_data); end
    nvec++; if (strm.rx_valid !== 1'b1)  begin nerr++; $display("FAIL t1_rxvalid: got %b want 1", strm.rx_valid); end
    nvec++; if (rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin nerr++; $display("FAIL t1_flags: got %b%b want 00", rx_overrun, tx_underrun); end
    nvec++; if (MISO_oe !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL t1_idle: got %b%b want 00", MISO_oe, busy); end
    nvec++; if (strm.tx_ready !== 1'b1)  begin nerr++; $display("FAIL t1_txready: got %b want 1", strm.tx_ready); end
    rx_take();
    nvec++; if (strm.rx_valid !== 1'b0)  begin nerr++; $display("FAIL t1_pop: got %b want 0", strm.rx_valid); end
  endtask

  task automatic test_underrun();
    logic [7:0] r;
    frame1(8'h01, r);
    nvec++; if (r !== 8'h00)            begin nerr++; $display("FAIL t2_miso: got %h want 00", r); end
    nvec++; if (strm.rx_data !== 8'h01) begin nerr++; $display("FAIL t2_rxdata: got %h want 01", strm.rx_data); end
    nvec++; if (tx_underrun !== 1'b1)   begin nerr++; $display("FAIL t2_und: got %b want 1", tx_underrun); end
    nvec++; if (rx_overrun !== 1'b0)    begin nerr++; $display("FAIL t2_ovr: got %b want 0", rx_overrun); end
    clear_flags();
    nvec++; if (tx_underrun !== 1'b0)   begin nerr++; $display("FAIL t2_clear: got %b want 0", tx_underrun); end
    rx_take();
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1;
    tx_put(8'h96);
    SS_n = 1'b0; clks(4);
    xfer_bits(8'h11, 8, r0);
    xfer_bits(8'h22, 8, r1);
    clks(2); SS_n = 1'b1; clks(6);
    nvec++; if (r0 !== 8'h96)           begin nerr++; $display("FAIL t3_miso0: got %h want 96", r0); end
    nvec++; if (r1 !== 8'h00)           begin nerr++; $display("FAIL t3_miso1: got %h want 00", r1); end
    nvec++; if (strm.rx_data !== 8'h22) begin nerr++; $display("FAIL t3_rxdata: got %h want 22", strm.rx_data); end
    nvec++; if (strm.rx_valid !== 1'b1) begin nerr++; $display("FAIL t3_rxvalid: got %b want 1", strm.rx_valid); end
    nvec++; if (rx_overrun !== 1'b1)    begin nerr++; $display("FAIL t3_ovr: got %b want 1", rx_overrun); end
    nvec++; if (tx_underrun !== 1'b1)   begin nerr++; $display("FAIL t3_und: got %b want 1", tx_underrun); end
    clear_flags(); rx_take();
    nvec++; if (rx_overrun !== 1'b0 || strm.rx_valid !== 1'b0) begin nerr++; $display("FAIL t3_cleanup: got %b%b want 00", rx_overrun, strm.rx_valid); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    SS_n = 1'b0; clks(4);
    xfer_bits(8'hF0, 4, r);
    SS_n = 1'b1; clks(6);
    nvec++; if (strm.rx_valid !== 1'b0) begin nerr++; $display("FAIL t4_norx: got %b want 0", strm.rx_valid); end
    nvec++; if (MISO_oe !== 1'b0 || MISO !== 1'b0) begin nerr++; $display("FAIL t4_oe: got %b%b want 00", MISO_oe, MISO); end
    frame1(8'h5A, r);
    nvec++; if (strm.rx_data !== 8'h5A || strm.rx_valid !== 1'b1) begin nerr++; $display("FAIL t4_rxdata: got %h/%b want 5a/1", strm.rx_data, strm.rx_valid); end
    clear_flags(); rx_take();
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    tx_put(8'h3E);
    SS_n = 1'b0; clks(4);
    xfer_bits(8'hAA, 3, r);
    reset = 1'b1; clks(2);
    nvec++; if (MISO !== 1'b0 || MISO_oe !== 1'b0) begin nerr++; $display("FAIL t5_pins: got %b%b want 00", MISO, MISO_oe); end
    nvec++; if (strm.rx_data !== 8'h00 || strm.rx_valid !== 1'b0) begin nerr++; $display("FAIL t5_rx: got %h/%b want 00/0", strm.rx_data, strm.rx_valid); end
    nvec++; if (busy !== 1'b0 || strm.tx_ready !== 1'b1) begin nerr++; $display("FAIL t5_busy_txr: got %b%b want 01", busy, strm.tx_ready); end
    reset = 1'b0; clks(2);
    xfer_bits(8'hAA, 5, r);
    clks(4);
    nvec++; if (strm.rx_valid !== 1'b0 || MISO_oe !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL t5_wait_ss: got %b%b%b want 000", strm.rx_valid, MISO_oe, busy); end
    SS_n = 1'b1; clks(6);
    tx_put(8'h7E);
    frame1(8'hC3, r);
    nvec++; if (r !== 8'h7E)            begin nerr++; $display("FAIL t5_miso: got %h want 7e", r); end
    nvec++; if (strm.rx_data !== 8'hC3 || strm.rx_valid !== 1'b1) begin nerr++; $display("FAIL t5_rxdata: got %h/%b want c3/1", strm.rx_data, strm.rx_valid); end
    nvec++; if (tx_underrun !== 1'b0)   begin nerr++; $display("FAIL t5_und: got %b want 0", tx_underrun); end
    rx_take();
  endtask

  task automatic test_tx_hold();
    logic [7:0] r;
    strm.tx_data = 8'hFF; strm.tx_valid = 1'b1; clks(1);
    strm.tx_data = 8'h00; clks(5);
    nvec++; if (strm.tx_ready !== 1'b0) begin nerr++; $display("FAIL t6_txready: got %b want 0", strm.tx_ready); end
    strm.tx_valid = 1'b0; clks(1);
    frame1(8'h00, r);
    nvec++; if (r !== 8'hFF)            begin nerr++; $display("FAIL t6_miso: got %h want ff", r); end
    nvec++; if (tx_underrun !== 1'b0)   begin nerr++; $display("FAIL t6_und0: got %b want 0", tx_underrun); end
    rx_take();
    frame1(8'h00, r);
    nvec++; if (tx_underrun !== 1'b1)   begin nerr++; $display("FAIL t6_und1: got %b want 1", tx_underrun); end
    nvec++; if (r !== 8'h00)            begin nerr++; $display("FAIL t6_miso2: got %h want 00", r); end
  endtask

  initial begin
    reset = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0; status_clear = 1'b0;
    strm.tx_data = 8'h00; strm.tx_valid = 1'b0; strm.rx_ready = 1'b0;
    clks(1);
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_tx_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
